// File: rtl/serijski_dekoder_pkg.sv
// Shared definitions for the serial decoder:
// default width, decode offsets and FSM states.
package serijski_dekoder_pkg;

    localparam int W_DEF    = 40;
    localparam int OFFSET_0 = 3;
    localparam int OFFSET_1 = 5;

    typedef enum logic [1:0] {
        IDLE,
        PRIJEM,
        DEKOD,
        IZLAZ
    } stanje_t;

endpackage

// File: rtl/serijski_dekoder_dekod_rec.sv
// Word decoder: removes the flag-selected offset
// and checks result parity against the flag.
module dekod_rec
    import serijski_dekoder_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W:0]   rec,
    output logic [W-1:0] vrijednost,
    output logic         greska
);

    // offset subtraction wraps modulo 2^W; error when LSB disagrees with flag
    always_comb begin
        vrijednost = '0;
        greska     = 1'b0;
        if (rec[W]) begin
            vrijednost = rec[W-1:0] - W'(OFFSET_1);
        end else begin
            vrijednost = rec[W-1:0] - W'(OFFSET_0);
        end
        greska = (vrijednost[0] != rec[W]);
    end

endmodule

// File: rtl/serijski_dekoder.sv
// Serial-in word decoder: collects W+1 bits MSB first,
// decodes them, and holds the result until accepted.
module serijski_dekoder
    import serijski_dekoder_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int GW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ser_in,
    input  logic          ser_valid,
    output logic          ser_ready,
    input  logic          prekid,
    output logic [W-1:0]  izlaz_dec,
    output logic          izlaz_greska,
    output logic          izlaz_valid,
    input  logic          izlaz_ready,
    output logic [GW-1:0] broj_gresaka
);

    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] ZADNJI = CW'(W);

    stanje_t       stanje;
    logic [CW-1:0] cnt;
    logic [W:0]    sr;
    logic [W-1:0]  dec_val;
    logic          dec_err;

    dekod_rec #(
        .W (W)
    ) u_dekod_rec (
        .rec        (sr),
        .vrijednost (dec_val),
        .greska     (dec_err)
    );

    assign ser_ready = (stanje == IDLE) || (stanje == PRIJEM);

    // receive / decode / present FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stanje       <= IDLE;
            cnt          <= '0;
            sr           <= '0;
            izlaz_valid  <= 1'b0;
            izlaz_dec    <= '0;
            izlaz_greska <= 1'b0;
            broj_gresaka <= '0;
        end else if (prekid) begin
            stanje      <= IDLE;
            cnt         <= '0;
            sr          <= '0;
            izlaz_valid <= 1'b0;
        end else begin
            unique case (stanje)
                IDLE: begin
                    if (ser_valid) begin
                        sr     <= {sr[W-1:0], ser_in};
                        cnt    <= CW'(1);
                        stanje <= PRIJEM;
                    end
                end
                PRIJEM: begin
                    if (ser_valid) begin
                        sr  <= {sr[W-1:0], ser_in};
                        cnt <= cnt + CW'(1);
                        if (cnt == ZADNJI) begin
                            stanje <= DEKOD;
                        end
                    end
                end
                DEKOD: begin
                    izlaz_dec    <= dec_val;
                    izlaz_greska <= dec_err;
                    izlaz_valid  <= 1'b1;
                    stanje       <= IZLAZ;
                end
                IZLAZ: begin
                    if (izlaz_ready) begin
                        izlaz_valid <= 1'b0;
                        stanje      <= IDLE;
                        if (izlaz_greska && (broj_gresaka != '1)) begin
                            broj_gresaka <= broj_gresaka + GW'(1);
                        end
                    end
                end
                default: begin
                    stanje <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serijski_dekoder.sv
// Scoreboard bench for serijski_dekoder: directed words,
// handshake stalls, abort, reset in output state, saturation.
module tb_serijski_dekoder;

    localparam int W  = 40;
    localparam int GW = 8;

    typedef struct {
        logic [W-1:0] dec;
        logic         greska;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          ser_in;
    logic          ser_valid;
    logic          ser_ready;
    logic          prekid;
    logic [W-1:0]  izlaz_dec;
    logic          izlaz_greska;
    logic          izlaz_valid;
    logic          izlaz_ready;
    logic [GW-1:0] broj_gresaka;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serijski_dekoder #(
        .W  (W),
        .GW (GW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ser_in       (ser_in),
        .ser_valid    (ser_valid),
        .ser_ready    (ser_ready),
        .prekid       (prekid),
        .izlaz_dec    (izlaz_dec),
        .izlaz_greska (izlaz_greska),
        .izlaz_valid  (izlaz_valid),
        .izlaz_ready  (izlaz_ready),
        .broj_gresaka (broj_gresaka)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // monitor: compare each accepted output word with the scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && izlaz_valid && izlaz_ready && !prekid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%h expected=none",
                         izlaz_dec);
            end else begin
                e = sb.pop_front();
                chk("sb_dec", 64'(izlaz_dec), 64'(e.dec));
                chk("sb_greska", 64'(izlaz_greska), 64'(e.greska));
            end
        end
    end

    task automatic send_bits(input logic [W:0] w, input int nbits,
                             input bit gaps);
        for (int i = W; i > W - nbits; i--) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    ser_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            ser_in    = w[i];
            ser_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        ser_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!izlaz_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_valid", 64'(izlaz_valid), 64'd1);
    endtask

    // word with ready=1: checks latency, scoreboard checks the value
    task automatic run_word(input logic [W:0] w, input logic [W-1:0] d,
                            input logic g, input bit gaps);
        exp_t e;
        e.dec    = d;
        e.greska = g;
        sb.push_back(e);
        send_bits(w, W + 1, gaps);
        chk("lat_edge1", 64'(izlaz_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2", 64'(izlaz_valid), 64'd1);
        @(posedge clk);
        #1;
        chk("after_hs", 64'(izlaz_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   seen;
        rst_n       = 1'b0;
        ser_in      = 1'b0;
        ser_valid   = 1'b0;
        prekid      = 1'b0;
        izlaz_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ser_ready", 64'(ser_ready), 64'd1);
        chk("rst_valid", 64'(izlaz_valid), 64'd0);
        chk("rst_dec", 64'(izlaz_dec), 64'd0);
        chk("rst_greska", 64'(izlaz_greska), 64'd0);
        chk("rst_broj", 64'(broj_gresaka), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_word({1'b0, 40'h0000000013}, 40'h0000000010, 1'b0, 1'b0);
        run_word({1'b1, 40'h000000000C}, 40'h0000000007, 1'b0, 1'b0);
        run_word({1'b0, 40'h0000000001}, 40'hFFFFFFFFFE, 1'b0, 1'b0);
        run_word({1'b0, 40'h0000000010}, 40'h000000000D, 1'b1, 1'b0);
        chk("broj_one", 64'(broj_gresaka), 64'd1);

        // stall output with ready low; gaps during reception
        izlaz_ready = 1'b0;
        e.dec    = 40'h1234567895;
        e.greska = 1'b0;
        sb.push_back(e);
        send_bits({1'b1, 40'h123456789A}, W + 1, 1'b1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 64'(izlaz_valid), 64'd1);
            chk("hold_dec", 64'(izlaz_dec), 64'h1234567895);
            chk("hold_ser_ready", 64'(ser_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        izlaz_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", 64'(izlaz_valid), 64'd0);

        // abort after 20 bits, with ser_valid on the same edge
        send_bits({1'b0, 40'hAAAAAAAAAA}, 20, 1'b0);
        prekid    = 1'b1;
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        @(posedge clk);
        #1;
        prekid    = 1'b0;
        ser_valid = 1'b0;
        chk("abort_ser_ready", 64'(ser_ready), 64'd1);
        seen = 1'b0;
        repeat (45) begin
            if (izlaz_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        run_word({1'b0, 40'h0000000105}, 40'h0000000102, 1'b0, 1'b0);

        // abort in output state beats izlaz_ready; word not counted
        izlaz_ready = 1'b0;
        send_bits({1'b0, 40'h0000000010}, W + 1, 1'b0);
        wait_valid();
        chk("iz_dec", 64'(izlaz_dec), 64'h000000000D);
        chk("iz_greska", 64'(izlaz_greska), 64'd1);
        prekid      = 1'b1;
        izlaz_ready = 1'b1;
        @(posedge clk);
        #1;
        prekid = 1'b0;
        chk("iz_abort_valid", 64'(izlaz_valid), 64'd0);
        chk("iz_abort_broj", 64'(broj_gresaka), 64'd1);
        chk("iz_abort_ready", 64'(ser_ready), 64'd1);

        // asynchronous reset while holding an output word
        izlaz_ready = 1'b0;
        send_bits({1'b0, 40'h0000000010}, W + 1, 1'b0);
        wait_valid();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(izlaz_valid), 64'd0);
        chk("arst_broj", 64'(broj_gresaka), 64'd0);
        chk("arst_dec", 64'(izlaz_dec), 64'd0);
        chk("arst_ser_ready", 64'(ser_ready), 64'd1);
        @(negedge clk);
        rst_n       = 1'b1;
        izlaz_ready = 1'b1;
        run_word({1'b1, 40'h000000000C}, 40'h0000000007, 1'b0, 1'b0);

        // error counter saturates at 255 after 256 error words
        for (int i = 0; i < 256; i++) begin
            e.dec    = 40'h000000000D;
            e.greska = 1'b1;
            sb.push_back(e);
            send_bits({1'b0, 40'h0000000010}, W + 1, 1'b0);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            if (i == 254) chk("broj_255", 64'(broj_gresaka), 64'd255);
        end
        chk("broj_sat", 64'(broj_gresaka), 64'd255);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serijski_dekoder.md
SERIJSKI_DEKODER -- requirements
Module: serijski_dekoder

Interface
REQ-001 Parameter W, default 40, payload width; an encoded word is W+1 bits (flag bit W, payload bits W-1:0).
REQ-002 Parameter GW, default 8, width of the error counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ser_in  input  1  serial encoded bit, MSB (flag, bit W) first.
REQ-006 ser_valid  input  1  ser_in is valid this cycle.
REQ-007 ser_ready  output  1  block accepts a serial bit this cycle.
REQ-008 prekid  input  1  synchronous abort; discards any partial or held frame.
REQ-009 izlaz_dec  output  W  decoded payload.
REQ-010 izlaz_greska  output  1  decoded word failed the consistency check; qualified by izlaz_valid.
REQ-011 izlaz_valid  output  1  izlaz_dec and izlaz_greska are valid.
REQ-012 izlaz_ready  input  1  downstream accepts the output word.
REQ-013 broj_gresaka  output  GW  saturating count of words delivered with izlaz_greska=1.

Function
REQ-014 A bit is accepted on an edge where ser_valid=1 and ser_ready=1; ser_valid=0 gaps stall reception without loss.
REQ-015 States: IDLE, PRIJEM, DEKOD, IZLAZ; ser_ready=1 only in IDLE and PRIJEM.
REQ-016 IDLE: an accepted bit is shifted into the W+1-bit shift register, bit counter becomes 1, next state PRIJEM.
REQ-017 PRIJEM: each accepted bit shifts in and increments the counter; the bit that completes W+1 bits moves the state to DEKOD.
REQ-018 DEKOD (one cycle): flag=0 gives izlaz_dec = (payload - 3) mod 2^W; flag=1 gives (payload - 5) mod 2^W; results registered, next state IZLAZ.
REQ-019 Consistency check: izlaz_greska = (izlaz_dec[0] != flag).
REQ-020 Latency: izlaz_valid asserts after the second rising edge following acceptance of the last bit.
REQ-021 IZLAZ: izlaz_valid=1 and outputs stay stable until an edge with izlaz_ready=1; that edge moves the state to IDLE.
REQ-022 On that handshake edge, broj_gresaka increments if izlaz_greska=1, saturating at 2^GW-1.
REQ-023 Wrap-around: an underflow below 0 wraps modulo 2^W; it is not an error in itself.
REQ-024 prekid=1 on any edge forces IDLE, clears the counter, and drops izlaz_valid; the current output word is not counted.
REQ-025 prekid has priority over ser_valid and izlaz_ready on the same edge.
REQ-026 broj_gresaka is unaffected by prekid.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE and sets the bit counter and shift register to 0.
REQ-028 Reset output values: ser_ready=1 (it follows the IDLE state), izlaz_valid=0, izlaz_dec=0, izlaz_greska=0, broj_gresaka=0.
REQ-029 Reset release is synchronous to clk; the first bit can be accepted on the first edge after release.

Structure
REQ-030 A shared package holds the default W, the offsets 3 and 5, and the state enumeration.
REQ-031 The combinational offset subtraction and flag check form one sub-module, dekod_rec (input W+1 bits; outputs W-bit value and error bit).

Verification
REQ-032 W=40, serial word 0x00000000013 (flag 0) -> izlaz_dec=0x0000000010, izlaz_greska=0, valid exactly 2 edges after the last bit.
REQ-033 Word {1, 0x000000000C} -> izlaz_dec=0x0000000007, izlaz_greska=0.
REQ-034 Word {0, 0x0000000001} -> izlaz_dec=0xFFFFFFFFFE (wrap), izlaz_greska=0.
REQ-035 Word {0, 0x0000000010} -> izlaz_dec=0x000000000D, izlaz_greska=1; after the handshake, broj_gresaka=1.
REQ-036 Hold izlaz_ready=0 for 10 cycles -> izlaz_valid and outputs stable, ser_ready=0; random ser_valid gaps during reception do not change the result.
REQ-037 prekid after 20 bits -> IDLE, no izlaz_valid; the next full word decodes correctly. rst_n low in IZLAZ -> izlaz_valid=0 immediately and broj_gresaka=0.
